// File: rtl/nios2_oci_pkg.sv
// Shared constants and types for the Nios II OCI data-compressed-trace path.
package nios2_oci_pkg;

   localparam int DCT_ATOM_W = 2;
   localparam int DCT_SLOTS  = 15;
   localparam int DCT_BUF_W  = DCT_ATOM_W * DCT_SLOTS;
   localparam int DCT_CNT_W  = 4;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      ENDING = 2'd1,
      ENDED  = 2'd2
   } dct_state_t;

   localparam logic [1:0] ATOM_CODE_0 = 2'd0;
   localparam logic [1:0] ATOM_CODE_1 = 2'd1;
   localparam logic [1:0] ATOM_CODE_2 = 2'd2;
   localparam logic [1:0] ATOM_CODE_3 = 2'd3;

endpackage

// File: rtl/nios2_oci_dct_out_slot.sv
// Single-entry valid/ready output register; a load takes priority and may
// overlap the handshake that empties the previous word.
module nios2_oci_dct_out_slot #(
   parameter int DATA_W = 30,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic [CNT_W-1:0]  load_count,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_count,
   output logic              free
);

   assign free = !out_valid || out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_count <= load_count;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot words for the trace FIFO and
// sequences the end-of-test flush (RUN -> ENDING -> ENDED).
module nios2_oci_dct_packer
   import nios2_oci_pkg::*;
#(
   parameter int ATOM_W = DCT_ATOM_W,
   parameter int SLOTS  = DCT_SLOTS
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     atm_valid,
   input  logic [ATOM_W-1:0]        atm_code,
   input  logic                     flush_req,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [ATOM_W*SLOTS-1:0]  out_data,
   output logic [DCT_CNT_W-1:0]     out_count,
   output logic [ATOM_W*SLOTS-1:0]  dct_buffer,
   output logic [DCT_CNT_W-1:0]     dct_count,
   output logic                     test_ending,
   output logic                     test_has_ended,
   output logic                     overflow
);

   localparam int BUF_W = ATOM_W * SLOTS;
   localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(SLOTS);
   localparam logic [DCT_CNT_W-1:0] LAST_CNT = DCT_CNT_W'(SLOTS - 1);

   dct_state_t                state, state_nx;
   logic [BUF_W-1:0]          buf_q, buf_nx;
   logic [DCT_CNT_W-1:0]      cnt_q, cnt_nx;
   logic                      ovf_q, ovf_nx;
   logic                      load;
   logic [BUF_W-1:0]          load_data;
   logic [DCT_CNT_W-1:0]      load_count;
   logic                      slot_free;
   logic [BUF_W-1:0]          atom_word;

   assign atom_word = BUF_W'(atm_code) << (ATOM_W * cnt_q);

   always_comb begin
      state_nx   = state;
      buf_nx     = buf_q;
      cnt_nx     = cnt_q;
      ovf_nx     = ovf_q;
      load       = 1'b0;
      load_data  = buf_q;
      load_count = cnt_q;
      case (state)
         RUN: begin
            if (cnt_q == FULL_CNT) begin
               if (slot_free) begin
                  // Full word leaves; a same-cycle atom starts the next word.
                  load       = 1'b1;
                  load_count = FULL_CNT;
                  buf_nx     = atm_valid ? BUF_W'(atm_code) : '0;
                  cnt_nx     = atm_valid ? DCT_CNT_W'(1) : '0;
               end else if (atm_valid) begin
                  ovf_nx = 1'b1;
               end
            end else if (atm_valid) begin
               buf_nx = buf_q | atom_word;
               cnt_nx = cnt_q + DCT_CNT_W'(1);
               if (cnt_q == LAST_CNT && slot_free) begin
                  load       = 1'b1;
                  load_data  = buf_q | atom_word;
                  load_count = FULL_CNT;
                  buf_nx     = '0;
                  cnt_nx     = '0;
               end
            end
            if (flush_req) state_nx = ENDING;
         end
         ENDING: begin
            if (slot_free) begin
               if (cnt_q != '0) begin
                  load   = 1'b1;
                  buf_nx = '0;
                  cnt_nx = '0;
               end else begin
                  state_nx = ENDED;
               end
            end
         end
         ENDED: ;
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
         buf_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nx;
         buf_q <= buf_nx;
         cnt_q <= cnt_nx;
         ovf_q <= ovf_nx;
      end
   end

   nios2_oci_dct_out_slot #(
      .DATA_W (BUF_W),
      .CNT_W  (DCT_CNT_W)
   ) u_out_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .load_data  (load_data),
      .load_count (load_count),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_count  (out_count),
      .free       (slot_free)
   );

   assign dct_buffer     = buf_q;
   assign dct_count      = cnt_q;
   assign overflow       = ovf_q;
   assign test_ending    = (state == ENDING);
   assign test_has_ended = (state == ENDED);

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Randomized and directed stimulus checked against a queue-based model of the packer.
module tb_nios2_oci_dct_packer;
   import nios2_oci_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        atm_valid;
   logic [1:0]  atm_code;
   logic        flush_req;
   logic        out_ready;
   logic        out_valid;
   logic [29:0] out_data;
   logic [3:0]  out_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_ending;
   logic        test_has_ended;
   logic        overflow;

   int n_vec = 0;
   int n_err = 0;

   // Model: atoms waiting in the buffer, the word in the output slot, state 0/1/2.
   int mq[$];
   int m_slot[$];
   bit m_vld;
   int m_st;
   bit m_ovf;

   nios2_oci_dct_packer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .atm_valid      (atm_valid),
      .atm_code       (atm_code),
      .flush_req      (flush_req),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_count      (out_count),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input int q[$]);
      logic [31:0] w = '0;
      foreach (q[i]) w = w | (32'(q[i]) << (2 * i));
      return w;
   endfunction

   task automatic compare_all();
      chk("dct_count", 32'(dct_count), 32'(mq.size()));
      chk("dct_buffer", 32'(dct_buffer), pack(mq));
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      if (m_vld) begin
         chk("out_data", 32'(out_data), pack(m_slot));
         chk("out_count", 32'(out_count), 32'(m_slot.size()));
      end
      chk("test_ending", 32'(test_ending), 32'(m_st == 1));
      chk("test_has_ended", 32'(test_has_ended), 32'(m_st == 2));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic model_step(input bit av, input int code, input bit fl, input bit rdy);
      bit free;
      free = !m_vld || rdy;
      if (free) m_vld = 1'b0;
      if (m_st == 0) begin
         if (mq.size() == 15) begin
            if (free) begin
               m_slot = mq;
               m_vld  = 1'b1;
               mq.delete();
               if (av) mq.push_back(code);
            end else if (av) begin
               m_ovf = 1'b1;
            end
         end else if (av) begin
            mq.push_back(code);
            if (mq.size() == 15 && free) begin
               m_slot = mq;
               m_vld  = 1'b1;
               mq.delete();
            end
         end
         if (fl) m_st = 1;
      end else if (m_st == 1) begin
         if (free) begin
            if (mq.size() > 0) begin
               m_slot = mq;
               m_vld  = 1'b1;
               mq.delete();
            end else begin
               m_st = 2;
            end
         end
      end
   endtask

   // Called at a falling edge; the next rising edge samples these inputs.
   task automatic cyc(input bit av, input logic [1:0] code, input bit fl, input bit rdy);
      atm_valid = av;
      atm_code  = code;
      flush_req = fl;
      out_ready = rdy;
      model_step(av, int'(code), fl, rdy);
      @(negedge clk);
      compare_all();
   endtask

   // Asserts reset between clock edges so the asynchronous clear is observable.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
      chk("rst_dct_count", 32'(dct_count), 32'd0);
      chk("rst_ending", 32'(test_ending), 32'd0);
      chk("rst_ended", 32'(test_has_ended), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      atm_valid = 1'b0;
      atm_code  = 2'd0;
      flush_req = 1'b0;
      out_ready = 1'b0;
      mq.delete();
      m_slot.delete();
      m_vld = 1'b0;
      m_st  = 0;
      m_ovf = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      atm_valid = 1'b0;
      atm_code  = 2'd0;
      flush_req = 1'b0;
      out_ready = 1'b0;
      m_vld = 1'b0;
      m_st  = 0;
      m_ovf = 1'b0;
      @(negedge clk);
      do_reset();
      compare_all();

      // Fifteen atoms cycling 0..3 with a ready sink.
      for (int i = 0; i < 15; i++) cyc(1'b1, 2'(i % 4), 1'b0, 1'b1);
      chk("pat_valid", 32'(out_valid), 32'd1);
      chk("pat_word", 32'(out_data), 32'h24E4E4E4);
      chk("pat_count", 32'(out_count), 32'd15);
      cyc(1'b0, ATOM_CODE_0, 1'b0, 1'b1);

      // 31 atoms into a stalled sink, then release with a code-3 atom.
      for (int i = 0; i < 31; i++) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
      chk("stall_ovf", 32'(overflow), 32'd1);
      chk("stall_cnt", 32'(dct_count), 32'd15);
      cyc(1'b1, ATOM_CODE_3, 1'b0, 1'b1);
      chk("xfer_cnt", 32'(dct_count), 32'd1);
      chk("xfer_buf", 32'(dct_buffer), 32'h3);
      chk("xfer_out_cnt", 32'(out_count), 32'd15);
      for (int i = 0; i < 3; i++) cyc(1'b0, ATOM_CODE_0, 1'b0, 1'b1);

      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 199) == 0,
                $urandom_range(0, 3) <= r);
      end

      // Partial-word flush with a stalled then released sink.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, ATOM_CODE_2, 1'b0, 1'b1);
      cyc(1'b0, ATOM_CODE_0, 1'b1, 1'b0);
      chk("fl_ending", 32'(test_ending), 32'd1);
      cyc(1'b1, ATOM_CODE_1, 1'b0, 1'b0);
      chk("fl_count", 32'(out_count), 32'd5);
      chk("fl_word", 32'(out_data), 32'h2AA);
      cyc(1'b0, ATOM_CODE_0, 1'b0, 1'b0);
      chk("fl_hold", 32'(test_has_ended), 32'd0);
      cyc(1'b1, ATOM_CODE_3, 1'b0, 1'b1);
      chk("fl_ended", 32'(test_has_ended), 32'd1);
      chk("fl_not_ending", 32'(test_ending), 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'($urandom), 1'($urandom), 1'b1);

      // Empty flush.
      do_reset();
      cyc(1'b0, ATOM_CODE_0, 1'b1, 1'b1);
      chk("ef_ending", 32'(test_ending), 32'd1);
      cyc(1'b0, ATOM_CODE_0, 1'b0, 1'b1);
      chk("ef_ended", 32'(test_has_ended), 32'd1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'($urandom), 1'b0, 1'($urandom));

      // Reset mid-word with a held output word.
      do_reset();
      for (int i = 0; i < 22; i++) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
      chk("mid_cnt", 32'(dct_count), 32'd7);
      chk("mid_vld", 32'(out_valid), 32'd1);
      do_reset();
      compare_all();
      cyc(1'b1, ATOM_CODE_1, 1'b0, 1'b1);
      chk("post_rst_cnt", 32'(dct_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
